add_sched: RTL and testbench
============================

# add_sched

Sequencer and round-robin arbiter that shares one combinational 64-bit KGP prefix adder among the VLIW issue slots. It accepts ADD/SUB requests from up to NUM_REQ slots and drives the shared adder's operand and carry-in inputs. It also chains two adder passes through a carry register to execute 128-bit operations. Results return on a single response channel tagged with the requester index.

## Interface
- NUM_REQ, 4, number of requesting issue slots (2..8)
- WIDTH, 64, width of the shared adder
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-slot request valid
- req_ready  out  NUM_REQ  per-slot accept, one-hot or zero
- req_op  in  2*NUM_REQ  per-slot opcode: 00 ADD, 01 SUB, 10 ADD128, 11 SUB128
- req_a  in  2*WIDTH*NUM_REQ  per-slot operand A; upper WIDTH ignored for 64-bit ops
- req_b  in  2*WIDTH*NUM_REQ  per-slot operand B; same rule
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  clog2(NUM_REQ)  index of the slot that issued the result
- rsp_sum  out  2*WIDTH  result; upper WIDTH is zero for 64-bit ops
- rsp_cout  out  1  final carry-out; for SUB it means no-borrow
- add_a  out  WIDTH  shared adder operand A
- add_b  out  WIDTH  shared adder operand B, already inverted for SUB
- add_cin  out  1  shared adder carry-in
- add_sum  in  WIDTH  shared adder sum
- add_cout  in  1  shared adder carry-out

## Operation
- States:
  - IDLE → EXEC_LO on accept.
  - EXEC_LO → EXEC_HI for a 128-bit op.
  - EXEC_LO → RESP for a 64-bit op.
  - EXEC_HI → RESP.
  - RESP → IDLE when rsp_ready is high.
- Arbitration: only in IDLE. The winner is the first valid slot scanning upward from pointer ptr, wrapping modulo NUM_REQ. req_ready is high only for the winner, combinationally. All other req_ready bits are 0, and all bits are 0 outside IDLE.
- Accept: when req_valid[w] and req_ready[w] are both high, latch op, A, B and w, then set ptr = (w+1) mod NUM_REQ.
- EXEC_LO:
  - add_a = A[WIDTH-1:0].
  - add_b = B[WIDTH-1:0], inverted for SUB.
  - add_cin = 1 for SUB, else 0.
  - Capture add_sum into result low half and add_cout into carry register.
- EXEC_HI:
  - add_a = A[2W-1:W].
  - add_b = B[2W-1:W], inverted for SUB.
  - add_cin = carry register.
  - Capture add_sum into result high half and add_cout into carry.
- RESP: rsp_valid = 1. rsp_sum, rsp_id and rsp_cout come from registers and stay stable until the handshake.
- Width rules: 64-bit ops clear the result high half. rsp_cout is the carry from the last pass. All arithmetic is modulo 2^(pass width).
- Adder drive outside EXEC_LO/EXEC_HI: add_a = 0, add_b = 0, add_cin = 0.
- Simultaneous requests: exactly one slot is granted per IDLE cycle. Losing slots keep their valid asserted and are not required to hold anything else.
- A requester may drop req_valid before being granted with no effect.

## Timing
- Reset values:
  - state IDLE, ptr 0, req_ready 0 until the first cycle after reset.
  - rsp_valid 0, rsp_id 0, rsp_sum 0, rsp_cout 0.
  - add_a 0, add_b 0, add_cin 0.
- rst mid-operation aborts the op with no response. An in-flight RESP is dropped.
- Latency from the accept edge T:
  - 64-bit: rsp_valid high from cycle T+2.
  - 128-bit: rsp_valid high from cycle T+3.
- Back-to-back throughput with rsp_ready held high:
  - one 64-bit op per 3 cycles.
  - one 128-bit op per 4 cycles.
- RESP with rsp_ready low stalls indefinitely. No new request is accepted during the stall.

## Structure
- Package add_sched_pkg holds:
  - opcode localparams OP_ADD, OP_SUB, OP_ADD128, OP_SUB128.
  - state encoding IDLE, EXEC_LO, EXEC_HI, RESP.
- One sub-module: rr_arbiter, parameterised by NUM_REQ.
  - Inputs: request vector, ptr.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; ptr is owned by add_sched.
- The shared adder is instantiated outside this block.

## Test plan
- Single ADD: slot 0, A=5, B=7. Expect rsp_sum=12, rsp_cout=0, rsp_id=0, rsp_valid at T+2.
- SUB with borrow: slot 1, A=3, B=5. Expect rsp_sum low = 0xFFFF_FFFF_FFFF_FFFE, rsp_cout=0. Then A=5, B=3: expect 2, rsp_cout=1.
- ADD128 carry chain:
  - Input: A = {0x0, 0xFFFF_FFFF_FFFF_FFFF}, B = {0x0, 0x1}.
  - Expect rsp_sum = {0x1, 0x0}, rsp_cout = 0, rsp_valid at T+3.
  - Verify add_cin = 1 during EXEC_HI.
- Round-robin: all 4 slots valid continuously from reset. Grant order is 0, 1, 2, 3, 0, and rsp_id follows the same order.
- Back-pressure: hold rsp_ready=0 for 5 cycles in RESP. Outputs stay stable, req_ready stays all-zero, and the result completes once rsp_ready=1.
- Reset in EXEC_HI of an ADD128: rsp_valid never asserts, state returns to IDLE, and the next request is granted to slot 0.

Source files
------------

// File: rtl/add_sched_pkg.sv
// Shared types and opcode definitions for the add_sched slice.
package add_sched_pkg;

  localparam logic [1:0] OP_ADD    = 2'b00;
  localparam logic [1:0] OP_SUB    = 2'b01;
  localparam logic [1:0] OP_ADD128 = 2'b10;
  localparam logic [1:0] OP_SUB128 = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC_LO = 2'd1,
    EXEC_HI = 2'd2,
    RESP    = 2'd3
  } state_t;

  // SUB and SUB128 invert operand B and inject a carry
  function automatic logic is_sub(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_SUB128);
  endfunction

  // 128-bit ops need a second adder pass
  function automatic logic is_wide(input logic [1:0] op);
    return (op == OP_ADD128) || (op == OP_SUB128);
  endfunction

endpackage

// File: rtl/add_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     idx
);

  // Scan upward from ptr, taking the first asserted request
  always_comb begin : p_scan
    logic [IDW:0] cand;
    logic         found;
    cand  = '0;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NUM_REQ)) begin
        cand = cand - (IDW+1)'(NUM_REQ);
      end
      if (!found && req[cand[IDW-1:0]]) begin
        found                  = 1'b1;
        grant[cand[IDW-1:0]]   = 1'b1;
        idx                    = cand[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/add_sched.sv
// Sequencer sharing one external WIDTH-bit adder among NUM_REQ issue slots,
// chaining two passes through a carry register for 128-bit ops.
module add_sched
  import add_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 64,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [2*NUM_REQ-1:0]         req_op,
  input  logic [2*WIDTH*NUM_REQ-1:0]   req_a,
  input  logic [2*WIDTH*NUM_REQ-1:0]   req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [IDW-1:0]               rsp_id,
  output logic [2*WIDTH-1:0]           rsp_sum,
  output logic                         rsp_cout,
  output logic [WIDTH-1:0]             add_a,
  output logic [WIDTH-1:0]             add_b,
  output logic                         add_cin,
  input  logic [WIDTH-1:0]             add_sum,
  input  logic                         add_cout
);

  state_t               state, state_nx;
  logic [IDW-1:0]       ptr, grant_idx, id_q;
  logic [NUM_REQ-1:0]   grant;
  logic [1:0]           op_q, sel_op;
  logic [2*WIDTH-1:0]   a_q, b_q, sel_a, sel_b, sum_q;
  logic                 carry_q;
  logic                 accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  // Select the winning slot's opcode and operands
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_op = req_op[2*i +: 2];
        sel_a  = req_a[2*WIDTH*i +: 2*WIDTH];
        sel_b  = req_b[2*WIDTH*i +: 2*WIDTH];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state, grant exposure and adder drive
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    accept    = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        // Grants are suppressed while reset is held so none leak out
        if (!rst) begin
          req_ready = grant;
          accept    = |grant;
          if (accept) begin
            state_nx = EXEC_LO;
          end
        end
      end
      EXEC_LO: begin
        add_a    = a_q[WIDTH-1:0];
        add_b    = b_q[WIDTH-1:0] ^ {WIDTH{is_sub(op_q)}};
        add_cin  = is_sub(op_q);
        state_nx = is_wide(op_q) ? EXEC_HI : RESP;
      end
      EXEC_HI: begin
        add_a    = a_q[2*WIDTH-1:WIDTH];
        add_b    = b_q[2*WIDTH-1:WIDTH] ^ {WIDTH{is_sub(op_q)}};
        add_cin  = carry_q;
        state_nx = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, pointer advance and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      id_q    <= '0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= sel_op;
        a_q  <= sel_a;
        b_q  <= sel_b;
        id_q <= grant_idx;
        ptr  <= (grant_idx == IDW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
      if (state == EXEC_LO) begin
        sum_q[WIDTH-1:0] <= add_sum;
        carry_q          <= add_cout;
        if (!is_wide(op_q)) begin
          sum_q[2*WIDTH-1:WIDTH] <= '0;
        end
      end
      if (state == EXEC_HI) begin
        sum_q[2*WIDTH-1:WIDTH] <= add_sum;
        carry_q                <= add_cout;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;

endmodule

// File: tb/tb_add_sched.sv
// Self-checking bench for add_sched with a behavioural shared adder.
module tb_add_sched;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid, req_ready;
  logic [7:0]   req_op;
  logic [511:0] req_a, req_b;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [127:0] rsp_sum;
  logic         rsp_cout;
  logic [63:0]  add_a, add_b, add_sum;
  logic         add_cin, add_cout;

  int checks = 0;
  int errors = 0;

  add_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  always #5 clk = ~clk;

  // External shared adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 65'(add_cin);

  // Reference result from plain wide arithmetic
  function automatic void ref_calc(input logic [1:0] op, input logic [127:0] a, input logic [127:0] b,
                                   output logic [127:0] s, output logic c);
    logic [128:0] t;
    t = '0;
    case (op)
      2'b00: begin
        t = {65'b0, a[63:0]} + {65'b0, b[63:0]};
        s = {64'b0, t[63:0]};
        c = t[64];
      end
      2'b01: begin
        s = {64'b0, a[63:0] - b[63:0]};
        c = (a[63:0] >= b[63:0]);
      end
      2'b10: begin
        t = {1'b0, a} + {1'b0, b};
        s = t[127:0];
        c = t[128];
      end
      default: begin
        s = a - b;
        c = (a >= b);
      end
    endcase
  endfunction

  // Issue one request from a single slot with rsp_ready high; returns observations
  task automatic run_op(input int unsigned slot, input logic [1:0] op, input logic [127:0] a,
                        input logic [127:0] b, output logic [127:0] sum, output logic cout,
                        output logic [1:0] id, output int unsigned lat, output bit ok);
    int unsigned n;
    ok = 1'b0; lat = 0; sum = '0; cout = 1'b0; id = '0; n = 0;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = '0;
    req_valid[slot] = 1'b1;
    req_op[2*slot +: 2]   = op;
    req_a[128*slot +: 128] = a;
    req_b[128*slot +: 128] = b;
    #1;
    while (!req_ready[slot] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (req_ready[slot]) begin
      @(posedge clk); #1;
      req_valid = '0;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
        @(posedge clk); #1; lat++;
      end
      if (rsp_valid) begin
        ok = 1'b1; sum = rsp_sum; cout = rsp_cout; id = rsp_id;
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_ready = 1'b1; req_valid = '1; req_op = '0;
    req_a = {16{$urandom}}; req_b = {16{$urandom}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d exp 0", rsp_id); end
    checks++; if (rsp_sum !== 128'd0) begin errors++; $display("FAIL reset_rsp_sum got %h exp 0", rsp_sum); end
    checks++; if (rsp_cout !== 1'b0) begin errors++; $display("FAIL reset_rsp_cout got %b exp 0", rsp_cout); end
    checks++; if ({add_a, add_b, add_cin} !== 129'd0) begin errors++; $display("FAIL reset_adder got %h %h %b exp 0", add_a, add_b, add_cin); end
    rst = 1'b0; req_valid = '0;
  endtask

  task automatic test_add();
    logic [127:0] s; logic c; logic [1:0] id; int unsigned lat; bit ok;
    run_op(0, 2'b00, 128'd5, 128'd7, s, c, id, lat, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL add_done got %b exp 1", ok); end
    checks++; if (s !== 128'd12) begin errors++; $display("FAIL add_sum got %h exp 12", s); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL add_cout got %b exp 0", c); end
    checks++; if (id !== 2'd0) begin errors++; $display("FAIL add_id got %0d exp 0", id); end
    checks++; if (lat != 2) begin errors++; $display("FAIL add_latency got %0d exp 2", lat); end
  endtask

  task automatic test_sub();
    logic [127:0] s; logic c; logic [1:0] id; int unsigned lat; bit ok;
    run_op(1, 2'b01, 128'd3, 128'd5, s, c, id, lat, ok);
    checks++; if (s !== {64'h0, 64'hFFFF_FFFF_FFFF_FFFE}) begin errors++; $display("FAIL sub_borrow_sum got %h exp 0000000000000000fffffffffffffffe", s); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL sub_borrow_cout got %b exp 0", c); end
    checks++; if (id !== 2'd1) begin errors++; $display("FAIL sub_borrow_id got %0d exp 1", id); end
    run_op(1, 2'b01, 128'd5, 128'd3, s, c, id, lat, ok);
    checks++; if (s !== 128'd2) begin errors++; $display("FAIL sub_sum got %h exp 2", s); end
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL sub_cout got %b exp 1", c); end
    checks++; if (lat != 2) begin errors++; $display("FAIL sub_latency got %0d exp 2", lat); end
  endtask

  task automatic test_add128();
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    req_op[5:4] = 2'b10;
    req_a[383:256] = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    req_b[383:256] = {64'h0, 64'h1};
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL add128_grant got %b exp 0100", req_ready); end
    @(posedge clk); #1; req_valid = '0;
    checks++; if ({add_a, add_b, add_cin} !== {64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0}) begin errors++; $display("FAIL add128_lo_drive got %h %h %b", add_a, add_b, add_cin); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add128_early_valid got %b exp 0", rsp_valid); end
    @(posedge clk); #1;
    checks++; if (add_cin !== 1'b1) begin errors++; $display("FAIL add128_hi_cin got %b exp 1", add_cin); end
    checks++; if ({add_a, add_b} !== 128'd0) begin errors++; $display("FAIL add128_hi_ops got %h %h exp 0 0", add_a, add_b); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add128_t2_valid got %b exp 0", rsp_valid); end
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL add128_t3_valid got %b exp 1", rsp_valid); end
    checks++; if (rsp_sum !== {64'h1, 64'h0}) begin errors++; $display("FAIL add128_sum got %h exp 00000000000000010000000000000000", rsp_sum); end
    checks++; if (rsp_cout !== 1'b0) begin errors++; $display("FAIL add128_cout got %b exp 0", rsp_cout); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL add128_id got %0d exp 2", rsp_id); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [127:0] a, b, s, es; logic c, ec; logic [1:0] id, op; int unsigned lat, slot; bit ok;
    for (int k = 0; k < 40; k++) begin
      slot = $urandom_range(0, 3);
      op   = 2'($urandom_range(0, 3));
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a[63:0] = '1;
      if ($urandom_range(0, 3) == 0) b = a;
      ref_calc(op, a, b, es, ec);
      run_op(slot, op, a, b, s, c, id, lat, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rand_done[%0d] got %b exp 1", k, ok); end
      checks++; if (s !== es) begin errors++; $display("FAIL rand_sum[%0d] op %0d got %h exp %h", k, op, s, es); end
      checks++; if (c !== ec) begin errors++; $display("FAIL rand_cout[%0d] op %0d got %b exp %b", k, op, c, ec); end
      checks++; if (id !== 2'(slot)) begin errors++; $display("FAIL rand_id[%0d] got %0d exp %0d", k, id, slot); end
      checks++; if (lat != (op[1] ? 3 : 2)) begin errors++; $display("FAIL rand_latency[%0d] got %0d exp %0d", k, lat, op[1] ? 3 : 2); end
    end
  endtask

  task automatic test_round_robin();
    logic [127:0] ta [4];
    logic [127:0] tb [4];
    logic [1:0]   top [4];
    logic [127:0] es; logic ec;
    int unsigned exp_q[$];
    int unsigned mptr, resps, cyc, last_cyc, grants, e;
    bit last_wide;
    mptr = 0; resps = 0; cyc = 0; last_cyc = 0; grants = 0; last_wide = 1'b0;
    @(negedge clk);
    rst = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      top[i] = 2'($urandom_range(0, 3));
      ta[i]  = {$urandom, $urandom, $urandom, $urandom};
      tb[i]  = {$urandom, $urandom, $urandom, $urandom};
      req_op[2*i +: 2]    = top[i];
      req_a[128*i +: 128] = ta[i];
      req_b[128*i +: 128] = tb[i];
    end
    req_valid = '1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    while (resps < 5 && cyc < 60) begin
      #1;
      if (req_ready != 4'b0) begin
        checks++; if (req_ready !== 4'(1 << mptr)) begin errors++; $display("FAIL rr_grant[%0d] got %b exp slot %0d", grants, req_ready, mptr); end
        if (grants > 0) begin
          checks++; if (cyc - last_cyc != (last_wide ? 4 : 3)) begin errors++; $display("FAIL rr_interval[%0d] got %0d exp %0d", grants, cyc - last_cyc, last_wide ? 4 : 3); end
        end
        exp_q.push_back(mptr);
        last_cyc = cyc; last_wide = top[mptr][1];
        mptr = (mptr + 1) % 4; grants++;
      end
      if (rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rr_unexpected_rsp got id %0d exp none", rsp_id);
        end else begin
          e = exp_q.pop_front();
          ref_calc(top[e], ta[e], tb[e], es, ec);
          if (rsp_id !== 2'(e) || rsp_sum !== es || rsp_cout !== ec) begin
            errors++; $display("FAIL rr_rsp[%0d] got id %0d sum %h c %b exp id %0d sum %h c %b", resps, rsp_id, rsp_sum, rsp_cout, e, es, ec);
          end
        end
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rr_ready_in_resp got %b exp 0000", req_ready); end
        resps++;
      end
      @(negedge clk); cyc++;
    end
    checks++; if (resps != 5) begin errors++; $display("FAIL rr_responses got %0d exp 5", resps); end
    req_valid = '0;
    @(negedge clk);
    // drain any op started on the final grant
    repeat (5) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [127:0] a, b, es; logic ec; int unsigned n;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    ref_calc(2'b11, a, b, es, ec);
    n = 0;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    req_op[7:6] = 2'b11; req_a[511:384] = a; req_b[511:384] = b;
    #1;
    while (!req_ready[3] && n < 20) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 4'b0011;
    n = 0;
    while (!rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", rsp_valid); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== es || rsp_cout !== ec || rsp_id !== 2'd3) begin
        errors++; $display("FAIL bp_hold[%0d] got v %b sum %h c %b id %0d exp v 1 sum %h c %b id 3", i, rsp_valid, rsp_sum, rsp_cout, rsp_id, es, ec);
      end
      checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0000", i, req_ready); end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", rsp_valid); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_next_grant got %b exp 0001", req_ready); end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int unsigned n;
    n = 0;
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    req_op[5:4] = 2'b10;
    req_a[383:256] = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    req_b[383:256] = {64'h0, 64'h1};
    #1;
    while (!req_ready[2] && n < 20) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    checks++; if (add_cin !== 1'b1) begin errors++; $display("FAIL rm_in_hi got cin %b exp 1", add_cin); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({add_a, add_b, add_cin} !== 129'd0) begin errors++; $display("FAIL rm_adder got %h %h %b exp 0", add_a, add_b, add_cin); end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_no_rsp[%0d] got %b exp 0", i, rsp_valid); end
      @(posedge clk); #1;
    end
    req_valid = '1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_grant got %b exp 0001", req_ready); end
    req_valid = '0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_add128();
    test_random();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
